calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Calculator front-end controller. It consumes the 5-bit key-event stream from the keypad scanner and assembles decimal operands A and B plus an operator. It issues each operation to the arithmetic unit over a valid/ready handshake, waits for the result, and drives the display value. It sits between the keypad scanner and the ALU/display path and is the only block that sequences the ALU.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must hold 10^MAX_DIGITS−1
- MAX_DIGITS, 4, max decimal digits per operand

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high; one clock, reset sampled on rising edge of clock
- key  in  5  key event: bit4=1 marks a new press (one-cycle pulse), [3:0]=key code; 5'b00000 = no event
- op_valid  out  1  operation request to ALU
- op_ready  in  1  ALU accepts request
- op_a  out  WIDTH  operand A
- op_b  out  WIDTH  operand B
- op_code  out  2  0=ADD(A), 1=SUB(B), 2=MUL(C), 3=DIV(D)
- res_valid  in  1  one-cycle result strobe from ALU
- res_value  in  WIDTH  result
- res_error  in  1  qualifies res_valid; overflow/divide-by-zero
- display  out  WIDTH  value to show
- err  out  1  error indicator
- busy  out  1  high while ISSUE or WAIT

## Operation
- Key codes: digits 1=0,4=1,7=2,0=3,2=4,5=5,8=6,3=8,6=9,9=10. A=12, B=13, C=14 and D=15 are operators. E=11 is equals. F=7 is clear.
- Digit append: acc ← acc*10 + d, only when digit count < MAX_DIGITS; otherwise the digit is silently dropped.
- States: ENTER_A, ENTER_B, ISSUE, WAIT, SHOW, ERROR. Reset → ENTER_A.
- ENTER_A:
  - Digit appends to A.
  - Operator latches op_code and goes to ENTER_B; with zero digits, A=0.
  - Equals is ignored.
- ENTER_B:
  - Digit appends to B.
  - Operator with zero B digits replaces op_code; with ≥1 B digit it is ignored.
  - Equals with ≥1 B digit → ISSUE; with zero B digits it is ignored.
- ISSUE: op_valid=1; op_a, op_b and op_code are held stable until op_valid&op_ready, then → WAIT.
- WAIT:
  - res_valid&!res_error → SHOW, R ← res_value.
  - res_valid&res_error → ERROR.
- SHOW:
  - Digit clears A, appends the digit, → ENTER_A.
  - Operator sets A ← R (chaining), latches op_code, → ENTER_B.
  - Equals is ignored.
- ERROR: err=1, display=0; only F leaves the state.
- Clear (F) in ENTER_A, ENTER_B, SHOW or ERROR: A=B=0, counts=0, err=0, → ENTER_A.
- In ISSUE and WAIT every key, including F, is ignored.
- res_valid is ignored in all states other than WAIT.
- Display source: ENTER_A → A. ENTER_B → B once ≥1 B digit is entered, else A. ISSUE/WAIT → B. SHOW → R. ERROR → 0.

## Timing
- All outputs are registered.
- Reset values: op_valid=0, op_a=op_b=0, op_code=0, display=0, err=0, busy=0.
- A key event on cycle n takes effect on outputs at n+1.
- Equals at n → op_valid=1 and busy=1 at n+1.
- Handshake at cycle m → op_valid=0 at m+1. The earliest accepted res_valid is at m+1.
- res_valid at w → display=R (or err=1) and busy=0 at w+1.
- Reset asserted mid-operation (any state): next cycle, all outputs are at reset values. op_valid drops without a handshake, and the ALU must tolerate this.
- A key event coincident with reset is discarded.

## Structure
- Shared package calc_pkg:
  - key-code localparams
  - op_code values (ADD/SUB/MUL/DIV)
  - state enum
  - key-event valid bit index (4)
- Sub-module key_decode (combinational): maps key[3:0] → is_digit, digit[3:0], is_op, op[1:0], is_eq, is_clr. It is shared with any future key consumer.
- Top holds the FSM, the A/B/R registers, the digit counters and the multiply-by-10 append (shift-add: (acc<<3)+(acc<<1)+d).

## Test plan
- 12+3: keys 0x10,0x14,0x1C,0x18,0x1B; op_ready=1; ALU returns res_value=15 → op_a=12, op_b=3, op_code=0, one op_valid pulse, display=15, busy low.
- Digit limit: keys 1,2,3,4,5 → display=1234; the fifth digit is dropped.
- Backpressure: issue 7×8 with op_ready=0 for 5 cycles and press keys meanwhile → op_valid stays high, op_a=7, op_b=8, op_code=2 stable, keys ignored, handshake on the 6th cycle.
- Chaining: from SHOW with R=15, keys B,5,E → op_a=15, op_b=5, op_code=1.
- Error: 5 D 0 E, ALU returns res_error=1 → err=1, display=0; digits, operators and equals are ignored; F → err=0, display=0, state ENTER_A.
- Reset during WAIT → next cycle op_valid=0, busy=0, display=0; a late res_valid is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: key codes, operator
// encodings, the sequencer state set and the key-event layout.
package calc_pkg;

    // Bit of the key event that marks a fresh press
    localparam int KEY_VLD_BIT = 4;

    // Keypad scan codes (matrix position, not the printed legend)
    localparam logic [3:0] KEY_DIG1 = 4'd0;
    localparam logic [3:0] KEY_DIG4 = 4'd1;
    localparam logic [3:0] KEY_DIG7 = 4'd2;
    localparam logic [3:0] KEY_DIG0 = 4'd3;
    localparam logic [3:0] KEY_DIG2 = 4'd4;
    localparam logic [3:0] KEY_DIG5 = 4'd5;
    localparam logic [3:0] KEY_DIG8 = 4'd6;
    localparam logic [3:0] KEY_CLR  = 4'd7;
    localparam logic [3:0] KEY_DIG3 = 4'd8;
    localparam logic [3:0] KEY_DIG6 = 4'd9;
    localparam logic [3:0] KEY_DIG9 = 4'd10;
    localparam logic [3:0] KEY_EQ   = 4'd11;
    localparam logic [3:0] KEY_ADD  = 4'd12;
    localparam logic [3:0] KEY_SUB  = 4'd13;
    localparam logic [3:0] KEY_MUL  = 4'd14;
    localparam logic [3:0] KEY_DIV  = 4'd15;

    // Operation codes presented to the ALU
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_ISSUE,
        ST_WAIT,
        ST_SHOW,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/key_decode.sv
// Combinational classifier for keypad scan codes. Splits a code into
// digit / operator / equals / clear and recovers the digit value.
module key_decode
    import calc_pkg::*;
(
    input  logic [3:0] code,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       is_op,
    output logic [1:0] op,
    output logic       is_eq,
    output logic       is_clr
);

    // Map each scan code to its key class and value
    always_comb begin
        is_digit = 1'b0;
        digit    = 4'd0;
        is_op    = 1'b0;
        op       = OP_ADD;
        is_eq    = 1'b0;
        is_clr   = 1'b0;
        case (code)
            KEY_DIG0: begin is_digit = 1'b1; digit = 4'd0; end
            KEY_DIG1: begin is_digit = 1'b1; digit = 4'd1; end
            KEY_DIG2: begin is_digit = 1'b1; digit = 4'd2; end
            KEY_DIG3: begin is_digit = 1'b1; digit = 4'd3; end
            KEY_DIG4: begin is_digit = 1'b1; digit = 4'd4; end
            KEY_DIG5: begin is_digit = 1'b1; digit = 4'd5; end
            KEY_DIG6: begin is_digit = 1'b1; digit = 4'd6; end
            KEY_DIG7: begin is_digit = 1'b1; digit = 4'd7; end
            KEY_DIG8: begin is_digit = 1'b1; digit = 4'd8; end
            KEY_DIG9: begin is_digit = 1'b1; digit = 4'd9; end
            KEY_EQ:   is_eq  = 1'b1;
            KEY_CLR:  is_clr = 1'b1;
            KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
                // Operator codes are contiguous, so the low bits are the op
                is_op = 1'b1;
                op    = code[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end sequencer: builds decimal operands from key events,
// issues the operation to the ALU over valid/ready, and drives the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       key,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [1:0]       op_code,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_value,
    input  logic             res_error,
    output logic [WIDTH-1:0] display,
    output logic             err,
    output logic             busy
);

    localparam int             CW      = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DIGITS);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a, a_nx, b, b_nx, r, r_nx, display_nx;
    logic [CW-1:0]    cnt_a, cnt_a_nx, cnt_b, cnt_b_nx;
    logic [1:0]       op_nx;

    logic             press, is_digit, is_op, is_eq, is_clr;
    logic [3:0]       digit;
    logic [1:0]       op;

    assign press = key[KEY_VLD_BIT];

    key_decode u_key_decode (
        .code     (key[3:0]),
        .is_digit (is_digit),
        .digit    (digit),
        .is_op    (is_op),
        .op       (op),
        .is_eq    (is_eq),
        .is_clr   (is_clr)
    );

    // acc*10 + d as shift-add, avoiding a multiplier
    function automatic logic [WIDTH-1:0] append_digit(input logic [WIDTH-1:0] acc,
                                                      input logic [3:0]       d);
        return (acc << 3) + (acc << 1) + {{(WIDTH-4){1'b0}}, d};
    endfunction

    assign op_a = a;
    assign op_b = b;

    // Next-state, operand update and display selection
    always_comb begin
        state_nx = state;
        a_nx     = a;
        b_nx     = b;
        r_nx     = r;
        cnt_a_nx = cnt_a;
        cnt_b_nx = cnt_b;
        op_nx    = op_code;

        unique case (state)
            ST_ENTER_A, ST_ENTER_B, ST_SHOW, ST_ERROR: begin
                if (press && is_clr) begin
                    a_nx     = '0;
                    b_nx     = '0;
                    cnt_a_nx = '0;
                    cnt_b_nx = '0;
                    state_nx = ST_ENTER_A;
                end else if (press) begin
                    if (state == ST_ENTER_A) begin
                        if (is_digit && cnt_a < MAX_CNT) begin
                            a_nx     = append_digit(a, digit);
                            cnt_a_nx = cnt_a + CW'(1);
                        end else if (is_op) begin
                            if (cnt_a == '0) a_nx = '0;
                            op_nx    = op;
                            b_nx     = '0;
                            cnt_b_nx = '0;
                            state_nx = ST_ENTER_B;
                        end
                    end else if (state == ST_ENTER_B) begin
                        if (is_digit && cnt_b < MAX_CNT) begin
                            b_nx     = append_digit(b, digit);
                            cnt_b_nx = cnt_b + CW'(1);
                        end else if (is_op && cnt_b == '0) begin
                            op_nx = op;
                        end else if (is_eq && cnt_b != '0) begin
                            state_nx = ST_ISSUE;
                        end
                    end else if (state == ST_SHOW) begin
                        if (is_digit) begin
                            // A fresh digit starts a new calculation
                            a_nx     = append_digit('0, digit);
                            cnt_a_nx = CW'(1);
                            state_nx = ST_ENTER_A;
                        end else if (is_op) begin
                            // Chain: previous result becomes the left operand
                            a_nx     = r;
                            op_nx    = op;
                            b_nx     = '0;
                            cnt_b_nx = '0;
                            state_nx = ST_ENTER_B;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (op_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (res_valid) begin
                    if (res_error) begin
                        state_nx = ST_ERROR;
                    end else begin
                        r_nx     = res_value;
                        state_nx = ST_SHOW;
                    end
                end
            end
            default: state_nx = ST_ENTER_A;
        endcase

        unique case (state_nx)
            ST_ENTER_A:          display_nx = a_nx;
            ST_ENTER_B:          display_nx = (cnt_b_nx != '0) ? b_nx : a_nx;
            ST_ISSUE, ST_WAIT:   display_nx = b_nx;
            ST_SHOW:             display_nx = r_nx;
            default:             display_nx = '0;
        endcase
    end

    // State, operand and registered-output update
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_ENTER_A;
            a        <= '0;
            b        <= '0;
            r        <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            op_code  <= OP_ADD;
            op_valid <= 1'b0;
            display  <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            a        <= a_nx;
            b        <= b_nx;
            r        <= r_nx;
            cnt_a    <= cnt_a_nx;
            cnt_b    <= cnt_b_nx;
            op_code  <= op_nx;
            op_valid <= (state_nx == ST_ISSUE);
            display  <= display_nx;
            err      <= (state_nx == ST_ERROR);
            busy     <= (state_nx == ST_ISSUE) || (state_nx == ST_WAIT);
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  key;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  op_code;
    logic        res_valid;
    logic [15:0] res_value;
    logic        res_error;
    logic [15:0] display;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    calc_sequencer #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_code   (op_code),
        .res_valid (res_valid),
        .res_value (res_value),
        .res_error (res_error),
        .display   (display),
        .err       (err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key = {1'b1, code};
        tick();
        key = 5'b00000;
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        key       = 5'h10;   // press coincident with reset must be lost
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_value = 16'd0;
        res_error = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        key   = 5'b00000;
        check_bit ("rst_op_valid", op_valid, 1'b0);
        check_word("rst_op_a",     op_a,     16'd0);
        check_word("rst_op_b",     op_b,     16'd0);
        check_word("rst_op_code",  16'(op_code), 16'd0);
        check_word("rst_display",  display,  16'd0);
        check_bit ("rst_err",      err,      1'b0);
        check_bit ("rst_busy",     busy,     1'b0);
        tick();
        check_word("rst_key_dropped", display, 16'd0);

        // 12 + 3
        op_ready = 1'b1;
        press(4'h0);  check_word("add_d1",  display, 16'd1);
        press(4'h4);  check_word("add_d12", display, 16'd12);
        press(4'hC);  check_word("add_opdisp", display, 16'd12);
        check_word("add_opcode_latched", 16'(op_code), 16'd0);
        press(4'h8);  check_word("add_b3", display, 16'd3);
        press(4'hB);
        check_bit ("add_valid_hi", op_valid, 1'b1);
        check_bit ("add_busy_hi",  busy,     1'b1);
        check_word("add_op_a",     op_a,     16'd12);
        check_word("add_op_b",     op_b,     16'd3);
        check_word("add_op_code",  16'(op_code), 16'd0);
        tick();
        check_bit ("add_valid_pulse", op_valid, 1'b0);
        check_bit ("add_busy_wait",   busy,     1'b1);
        check_word("add_wait_disp",   display,  16'd3);
        res_valid = 1'b1; res_value = 16'd15;
        tick();
        res_valid = 1'b0;
        check_word("add_result", display, 16'd15);
        check_bit ("add_busy_lo", busy, 1'b0);
        check_bit ("add_err_lo",  err,  1'b0);

        // Digit limit: 1 2 3 4 5 from SHOW
        press(4'h0);  check_word("lim_d1", display, 16'd1);
        press(4'h4);
        press(4'h8);
        press(4'h1);  check_word("lim_1234", display, 16'd1234);
        press(4'h5);  check_word("lim_5th_dropped", display, 16'd1234);
        check_word("lim_op_a", op_a, 16'd1234);
        press(4'h7);  check_word("lim_clear", display, 16'd0);
        press(4'hB);  check_bit ("eq_ignored_in_a", op_valid, 1'b0);

        // Backpressure: 7 x 8 with op_ready low for five cycles
        op_ready = 1'b0;
        press(4'h2);
        press(4'hE);
        press(4'h6);
        press(4'hB);
        check_bit("bp_valid_start", op_valid, 1'b1);
        press(4'h7);  check_bit ("bp_valid_c1", op_valid, 1'b1);
        press(4'h3);  check_word("bp_op_a_c2",  op_a, 16'd7);
        press(4'hB);  check_word("bp_op_b_c3",  op_b, 16'd8);
        press(4'hC);  check_word("bp_op_code_c4", 16'(op_code), 16'd2);
        press(4'h9);  check_word("bp_disp_c5", display, 16'd8);
        check_bit("bp_valid_c5", op_valid, 1'b1);
        op_ready = 1'b1;
        tick();
        check_bit("bp_handshake", op_valid, 1'b0);
        press(4'h7);  check_bit("bp_clr_ignored_wait", busy, 1'b1);
        res_valid = 1'b1; res_value = 16'd56;
        tick();
        res_valid = 1'b0;
        check_word("bp_result", display, 16'd56);

        // Chaining from SHOW with R = 15
        press(4'h0); press(4'h4); press(4'hC); press(4'h8); press(4'hB);
        tick();
        res_valid = 1'b1; res_value = 16'd15;
        tick();
        res_valid = 1'b0;
        check_word("ch_r15", display, 16'd15);
        press(4'hD);  check_word("ch_disp_a", display, 16'd15);
        press(4'h5);
        press(4'hB);
        check_bit ("ch_valid",   op_valid, 1'b1);
        check_word("ch_op_a",    op_a,     16'd15);
        check_word("ch_op_b",    op_b,     16'd5);
        check_word("ch_op_code", 16'(op_code), 16'd1);
        tick();
        res_valid = 1'b1; res_value = 16'd10;
        tick();
        res_valid = 1'b0;
        check_word("ch_result", display, 16'd10);

        // Error path: 5 C D 0 A E, ALU flags an error
        press(4'h5);
        press(4'hE);
        press(4'hF);  check_word("err_op_replaced", 16'(op_code), 16'd3);
        press(4'h3);  check_word("err_b0", display, 16'd0);
        press(4'hC);  check_word("err_op_kept", 16'(op_code), 16'd3);
        press(4'hB);
        check_word("err_op_a", op_a, 16'd5);
        check_word("err_op_b", op_b, 16'd0);
        tick();
        res_valid = 1'b1; res_error = 1'b1; res_value = 16'd77;
        tick();
        res_valid = 1'b0; res_error = 1'b0;
        check_bit ("err_set",   err,     1'b1);
        check_word("err_disp0", display, 16'd0);
        check_bit ("err_busy0", busy,    1'b0);
        press(4'hA);
        press(4'hC);
        press(4'hB);
        check_bit ("err_sticky", err,      1'b1);
        check_bit ("err_no_issue", op_valid, 1'b0);
        res_valid = 1'b1; res_value = 16'd33;
        tick();
        res_valid = 1'b0;
        check_word("err_res_ignored", display, 16'd0);
        press(4'h7);
        check_bit ("err_cleared", err,     1'b0);
        check_word("err_clr_disp", display, 16'd0);
        press(4'h4);  check_word("err_enter_a", display, 16'd2);

        // Equals with zero B digits is ignored, then reset during WAIT
        press(4'hC);
        press(4'hB);  check_bit("eq_ignored_no_b", op_valid, 1'b0);
        press(4'h8);
        press(4'hB);  check_bit("rw_issue", op_valid, 1'b1);
        tick();
        check_bit("rw_in_wait", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit ("rw_valid",   op_valid, 1'b0);
        check_bit ("rw_busy",    busy,     1'b0);
        check_word("rw_display", display,  16'd0);
        check_word("rw_op_a",    op_a,     16'd0);
        res_valid = 1'b1; res_value = 16'd99;
        tick();
        res_valid = 1'b0;
        check_word("rw_late_res", display, 16'd0);
        check_bit ("rw_late_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
